// File: rtl/jc_pkg.sv
// rtl/jc_pkg.sv - shared types, constants and helpers for the Johnson phase monitor
// Contents:
//   JC_N        default Johnson counter width
//   jc_state_e  lock state (UNLOCKED, LOCKED)
//   ERR_*       sticky error codes reported on o_err_code
//   jc_canon    canonical Johnson code for a phase index of an n-bit counter
package jc_pkg;

   localparam int JC_N = 3;

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } jc_state_e;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_CODE = 2'b01;
   localparam logic [1:0] ERR_STEP = 2'b10;

   // The counter shifts left and feeds ~MSB into bit 0, so phases 0..n fill
   // ones from the bottom and phases n+1..2n-1 clear ones from the bottom.
   function automatic logic [31:0] jc_canon(input int n, input int phase);
      logic [31:0] ones;
      ones = (32'd1 << n) - 32'd1;
      if (phase <= n) begin
         return (32'd1 << phase) - 32'd1;
      end
      return ones & ~((32'd1 << (phase - n)) - 32'd1);
   endfunction

endpackage

// File: rtl/jc_decode.sv
// rtl/jc_decode.sv - combinational Johnson code to phase index decoder
// Ports:
//   i_q      Johnson code sample
//   o_phase  phase index 0..2N-1 implied by the code
//   o_legal  code is exactly the canonical code for o_phase
module jc_decode
   import jc_pkg::*;
#(
   parameter int N  = JC_N,
   parameter int PW = $clog2(2 * N)
) (
   input  logic [N-1:0]  i_q,
   output logic [PW-1:0] o_phase,
   output logic          o_legal
);

   int          pc;
   int          ph;
   logic [31:0] canon;

   always_comb begin
      pc = 0;
      for (int i = 0; i < N; i++) begin
         pc = pc + int'(i_q[i]);
      end
      // A set LSB (or all-zero) means the ones are still filling up;
      // otherwise the ones are draining and the phase counts past N.
      if (i_q[0] || (i_q == '0)) begin
         ph = pc;
      end else begin
         ph = 2 * N - pc;
      end
      canon   = jc_canon(N, ph);
      o_phase = PW'(ph);
      o_legal = (canon == 32'(i_q));
   end

endmodule

// File: rtl/jc_phase_monitor.sv
// rtl/jc_phase_monitor.sv - Johnson counter phase decoder, lock tracker and error monitor
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_valid     i_Q holds a new counter sample
//   i_Q         Johnson code from the counter
//   i_clr_err   clears the sticky error flag and code
//   o_phase     one-hot phase of the last legal sample, zero if none
//   o_locked    monitor is locked to the sequence
//   o_wrap      one-cycle pulse on a locked step from the last phase to phase 0
//   o_cycles    revolutions completed while locked, modulo 2^CW
//   o_err       sticky error flag
//   o_err_code  first error seen: ERR_CODE illegal code, ERR_STEP bad step
module jc_phase_monitor
   import jc_pkg::*;
#(
   parameter int N        = JC_N,
   parameter int LOCK_CNT = 4,
   parameter int CW       = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   input  logic [N-1:0]  i_Q,
   input  logic          i_clr_err,
   output logic [2*N-1:0] o_phase,
   output logic          o_locked,
   output logic          o_wrap,
   output logic [CW-1:0] o_cycles,
   output logic          o_err,
   output logic [1:0]    o_err_code
);

   localparam int              P       = 2 * N;
   localparam int              PW      = $clog2(P);
   localparam logic [PW-1:0]   LAST_PH = PW'(P - 1);
   localparam logic [3:0]      LOCK_V  = 4'(LOCK_CNT);

   jc_state_e      state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [PW-1:0]  prev_q, prev_d;
   logic [P-1:0]   phase_q, phase_d;
   logic           wrap_q, wrap_d;
   logic [CW-1:0]  cycles_q, cycles_d;
   logic           err_q, err_d;
   logic [1:0]     err_code_q, err_code_d;

   logic [PW-1:0]  dec_phase;
   logic           dec_legal;
   logic [P-1:0]   dec_onehot;
   logic [PW-1:0]  expect_ph;
   logic           good_step;
   logic [3:0]     cnt_inc;
   logic           err_event;
   logic [1:0]     err_kind;

   jc_decode #(.N(N), .PW(PW)) u_decode (
      .i_q     (i_Q),
      .o_phase (dec_phase),
      .o_legal (dec_legal)
   );

   always_comb begin
      dec_onehot = {{(P-1){1'b0}}, 1'b1} << dec_phase;
      expect_ph  = (prev_q == LAST_PH) ? '0 : prev_q + 1'b1;
      good_step  = (dec_phase == expect_ph);
      // Lock depth never exceeds 15, so saturating keeps the counter sane
      // if it lingers while locked.
      cnt_inc    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      prev_d     = prev_q;
      phase_d    = phase_q;
      wrap_d     = 1'b0;
      cycles_d   = cycles_q;
      err_d      = err_q;
      err_code_d = err_code_q;
      err_event  = 1'b0;
      err_kind   = ERR_NONE;

      if (i_valid) begin
         case (state_q)
            UNLOCKED: begin
               if (!dec_legal) begin
                  cnt_d   = '0;
                  phase_d = '0;
               end else begin
                  prev_d  = dec_phase;
                  phase_d = dec_onehot;
                  // An empty run or a broken step starts a fresh run at this sample.
                  if ((cnt_q == '0) || !good_step) begin
                     cnt_d = 4'd1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
                  if (cnt_d >= LOCK_V) begin
                     state_d = LOCKED;
                  end
               end
            end
            LOCKED: begin
               if (!dec_legal) begin
                  state_d   = UNLOCKED;
                  cnt_d     = '0;
                  phase_d   = '0;
                  err_event = 1'b1;
                  err_kind  = ERR_CODE;
               end else if (!good_step) begin
                  state_d   = UNLOCKED;
                  cnt_d     = 4'd1;
                  prev_d    = dec_phase;
                  phase_d   = dec_onehot;
                  err_event = 1'b1;
                  err_kind  = ERR_STEP;
               end else begin
                  prev_d  = dec_phase;
                  phase_d = dec_onehot;
                  if ((prev_q == LAST_PH) && (dec_phase == '0)) begin
                     wrap_d   = 1'b1;
                     cycles_d = cycles_q + 1'b1;
                  end
               end
            end
            default: state_d = UNLOCKED;
         endcase
      end

      // A clear in the same cycle as a new error yields to the new error.
      if (err_event && (!err_q || i_clr_err)) begin
         err_d      = 1'b1;
         err_code_d = err_kind;
      end else if (i_clr_err) begin
         err_d      = 1'b0;
         err_code_d = ERR_NONE;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= UNLOCKED;
         cnt_q      <= '0;
         prev_q     <= '0;
         phase_q    <= '0;
         wrap_q     <= 1'b0;
         cycles_q   <= '0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         prev_q     <= prev_d;
         phase_q    <= phase_d;
         wrap_q     <= wrap_d;
         cycles_q   <= cycles_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign o_phase    = phase_q;
   assign o_locked   = (state_q == LOCKED);
   assign o_wrap     = wrap_q;
   assign o_cycles   = cycles_q;
   assign o_err      = err_q;
   assign o_err_code = err_code_q;

endmodule

// File: tb/tb_jc_phase_monitor.sv
// tb/tb_jc_phase_monitor.sv - scoreboard bench for jc_phase_monitor
module tb_jc_phase_monitor;

   localparam int LOCK = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [2:0] q;
   logic       clr;
   logic [5:0] o_phase;
   logic       o_locked;
   logic       o_wrap;
   logic [7:0] o_cycles;
   logic       o_err;
   logic [1:0] o_err_code;

   jc_phase_monitor #(.N(3), .LOCK_CNT(LOCK), .CW(8)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_valid    (valid),
      .i_Q        (q),
      .i_clr_err  (clr),
      .o_phase    (o_phase),
      .o_locked   (o_locked),
      .o_wrap     (o_wrap),
      .o_cycles   (o_cycles),
      .o_err      (o_err),
      .o_err_code (o_err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      int phase;
      int locked;
      int wrap;
      int cycles;
      int err;
      int code;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   int codes [6] = '{0, 1, 3, 7, 6, 4};
   int m_locked, m_run, m_prev, m_phase, m_wrap, m_cycles, m_err, m_code;
   int gen;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int find_phase(input int code);
      for (int i = 0; i < 6; i++) begin
         if (codes[i] == code) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_locked = 0; m_run = 0; m_prev = 0; m_phase = 0;
      m_wrap = 0; m_cycles = 0; m_err = 0; m_code = 0;
   endtask

   task automatic raise(input int code);
      if (m_err == 0) begin
         m_err  = 1;
         m_code = code;
      end
   endtask

   task automatic model(input logic v, input int code, input logic c);
      int  idx;
      bit  good;
      m_wrap = 0;
      if (c) begin
         m_err  = 0;
         m_code = 0;
      end
      if (v) begin
         idx  = find_phase(code);
         good = (idx >= 0) && (m_run > 0) && (idx == (m_prev + 1) % 6);
         if (m_locked == 0) begin
            if (idx < 0) begin
               m_run   = 0;
               m_phase = 0;
            end else begin
               m_run   = good ? m_run + 1 : 1;
               m_prev  = idx;
               m_phase = 1 << idx;
               if (m_run >= LOCK) m_locked = 1;
            end
         end else if (idx < 0) begin
            m_locked = 0; m_run = 0; m_phase = 0;
            raise(1);
         end else if (!good) begin
            m_locked = 0; m_run = 1; m_prev = idx; m_phase = 1 << idx;
            raise(2);
         end else begin
            if (m_prev == 5 && idx == 0) begin
               m_wrap   = 1;
               m_cycles = (m_cycles + 1) % 256;
            end
            m_prev  = idx;
            m_phase = 1 << idx;
         end
      end
   endtask

   task automatic step(input logic v, input logic [2:0] qq, input logic c);
      exp_t e;
      valid = v;
      q     = qq;
      clr   = c;
      @(posedge clk);
      model(v, int'(qq), c);
      e.phase = m_phase; e.locked = m_locked; e.wrap = m_wrap;
      e.cycles = m_cycles; e.err = m_err; e.code = m_code;
      sb.push_back(e);
      #1;
      valid = 1'b0;
      clr   = 1'b0;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("phase",    int'(o_phase),    mon_e.phase);
         check("locked",   int'(o_locked),   mon_e.locked);
         check("wrap",     int'(o_wrap),     mon_e.wrap);
         check("cycles",   int'(o_cycles),   mon_e.cycles);
         check("err",      int'(o_err),      mon_e.err);
         check("err_code", int'(o_err_code), mon_e.code);
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_phase"},  int'(o_phase),    0);
      check({tag, "_locked"}, int'(o_locked),   0);
      check({tag, "_wrap"},   int'(o_wrap),     0);
      check({tag, "_cycles"}, int'(o_cycles),   0);
      check({tag, "_err"},    int'(o_err),      0);
      check({tag, "_code"},   int'(o_err_code), 0);
   endtask

   initial begin
      int r;
      int cd;
      logic v;
      rst = 1'b1; valid = 1'b0; q = 3'b000; clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Acquire lock, then one revolution and 256 more
      foreach (codes[i]) step(1'b1, 3'(codes[i]), 1'b0);
      step(1'b1, 3'b000, 1'b0);
      for (int rev = 0; rev < 256; rev++) begin
         for (int i = 1; i < 6; i++) step(1'b1, 3'(codes[i]), 1'b0);
         step(1'b1, 3'b000, 1'b0);
      end
      @(negedge clk); #1;
      check("cycles_wrapped", int'(o_cycles), 1);

      // Illegal code while locked, then another illegal code
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b011, 1'b0);
      step(1'b1, 3'b101, 1'b0);
      step(1'b1, 3'b010, 1'b0);

      // Relock (clearing error), reach 001, skip to 111, relock after 000
      step(1'b1, 3'b000, 1'b1);
      foreach (codes[i]) if (i > 0) step(1'b1, 3'(codes[i]), 1'b0);
      step(1'b1, 3'b000, 1'b0);
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b110, 1'b0);
      step(1'b1, 3'b100, 1'b0);
      step(1'b1, 3'b000, 1'b0);

      // Idle cycles with garbage, then a repeated code
      for (int i = 0; i < 10; i++) step(1'b0, 3'($urandom_range(0, 7)), 1'b0);
      step(1'b1, 3'b001, 1'b1);
      step(1'b1, 3'b011, 1'b0);
      step(1'b1, 3'b011, 1'b0);

      // Clear coinciding with an illegal sample after relocking
      foreach (codes[i]) if (i > 0) step(1'b1, 3'(codes[i]), 1'b0);
      step(1'b1, 3'b000, 1'b0);
      step(1'b1, 3'b010, 1'b1);

      // Relock and reset asynchronously mid-lock
      step(1'b1, 3'b000, 1'b0);
      step(1'b1, 3'b001, 1'b0);
      step(1'b1, 3'b011, 1'b0);
      step(1'b1, 3'b111, 1'b0);
      step(1'b1, 3'b110, 1'b0);
      @(negedge clk); #2;
      check("pre_rst_locked", int'(o_locked), m_locked);
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Randomized traffic
      gen = 5;
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         v = ($urandom_range(0, 99) < 85);
         if (r < 70)      cd = codes[(gen + 1) % 6];
         else if (r < 80) cd = codes[gen];
         else if (r < 90) cd = codes[$urandom_range(0, 5)];
         else             cd = int'($urandom_range(0, 7));
         if (v && find_phase(cd) >= 0) gen = find_phase(cd);
         step(v, 3'(cd), ($urandom_range(0, 49) == 0));
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/jc_phase_monitor.md
Name: jc_phase_monitor

Overview:
- Downstream consumer of the 3-bit Johnson counter output.
- Samples the counter code and decodes it to a one-hot phase.
- Checks every code and every step against the legal Johnson sequence, acquires/loses lock, counts completed revolutions, and raises sticky error flags.
- Sits between the Johnson counter and any logic that needs clean phase strobes or a health indication.

Parameters:
- N, 3, Johnson counter width; sequence length is 2N.
- LOCK_CNT, 4, consecutive legal samples (including the first) required to assert lock; range 1..15.
- CW, 8, width of revolution counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_Q is a new counter sample this cycle.
- i_Q  input  N  Johnson code from counter.
- i_clr_err  input  1  clears o_err/o_err_code.
- o_phase  output  2N  one-hot decoded phase of last legal sample; all-zero if none.
- o_locked  output  1  monitor locked to sequence.
- o_wrap  output  1  one-cycle pulse: locked step from phase 2N-1 to 0.
- o_cycles  output  CW  revolutions counted while locked; wraps modulo 2^CW.
- o_err  output  1  sticky error flag.
- o_err_code  output  2  01 illegal code, 10 bad step, 00 none; sticky, first error wins.

Behaviour:
- Reset (async, i_rst=1): state UNLOCKED, lock count 0, prev phase 0. All outputs are 0.
- Legal sequence is the counter's shift-left, ~MSB-in order: 000→001→011→111→110→100→000. These are phases 0..5.
- Decode (combinational, generic N):
  - If Q[0]=1 or Q=0: phase = popcount(Q); otherwise phase = 2N − popcount(Q).
  - Q is legal iff it equals the canonical code for that phase.
  - For N=3, 010 and 101 are illegal.
- All outputs are registered with 1-cycle latency from the i_valid sample. When i_valid=0, all state holds and o_wrap=0.
- Step rule: a sample is a good step iff phase == (prev+1) mod 2N. A repeated code is a bad step.
- UNLOCKED state:
  - Illegal code: cnt=0, o_phase=0.
  - Legal code with cnt=0 or a bad step: prev=phase, cnt=1, o_phase=onehot(phase).
  - Legal good step: prev=phase, cnt++, o_phase updated.
  - When cnt reaches LOCK_CNT → LOCKED; o_locked=1 on the same registered edge.
  - LOCK_CNT=1 means lock on the first legal sample.
  - No errors are flagged in UNLOCKED.
- LOCKED state:
  - Good step: o_phase updated. If prev=2N-1 and phase=0: o_wrap=1 and o_cycles++ (wraps at 2^CW-1→0).
  - Illegal code: → UNLOCKED, cnt=0, o_phase=0, o_locked=0, error code 01.
  - Bad step (legal code): → UNLOCKED, cnt=1, prev=phase, o_phase=onehot(phase), o_locked=0, error code 10.
- Error register:
  - If o_err=0 on an error: o_err=1 and o_err_code is loaded. A later error does not change o_err_code.
  - i_clr_err clears both. If clear and a new error occur in the same cycle, the new error is latched.
- o_cycles is never cleared except by reset. It holds its value across loss of lock.
- Reset asserted mid-sequence returns everything to reset values immediately (asynchronously). Relock needs LOCK_CNT samples.

Decomposition:
- Package jc_pkg:
  - default N;
  - state enum {UNLOCKED, LOCKED};
  - error code constants ERR_NONE=2'b00, ERR_CODE=2'b01, ERR_STEP=2'b10;
  - function jc_canon(phase) returning the canonical code.
- One combinational sub-module jc_decode: input Q[N-1:0]; outputs phase index [$clog2(2N)-1:0] and legal.
- FSM, counters and error register live in jc_phase_monitor.

Test Plan:
1. Reset, then feed 000,001,011,111 with i_valid=1 (LOCK_CNT=4) → o_locked rises the cycle after 111. o_phase goes 000001,000010,000100,001000. o_err=0.
2. Locked; continue 110,100,000 → o_wrap pulses exactly once, one cycle after the 000 sample. o_cycles 0→1. Run 256 revolutions (CW=8) → o_cycles wraps back to 1.
3. Locked at 011; inject 101 → o_locked=0, o_phase=0, o_err=1, o_err_code=01. Then 010 → code stays 01.
4. Locked at 001; inject 111 (skip) → o_err_code=10, o_phase=001000. Then 110,100,000 → relock after the 4th legal step (111,110,100,000).
5. Locked; hold i_valid=0 for 10 cycles with garbage on i_Q → no state or output change. Repeat 011 twice with valid → bad-step error 10.
6. Error pending; assert i_clr_err together with an illegal-code sample → o_err stays 1 with code 01. Assert i_rst mid-lock → all outputs 0 asynchronously, before the next clock edge.
